// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: sequencer for a multi-operand carry-save accumulator.
//
// Operand pairs are absorbed one per cycle into a redundant (S, C) state
// through a row of WIDTH 4:2 compressors. No carry propagates in this loop.
// After the last beat, the redundant state is resolved to binary by
// iterating a half-adder row until C is zero. The result is then offered on
// a valid/ready output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               job request, honoured only while idle
//   busy                job in flight (start accept .. output handshake)
//   in_valid/in_ready   operand beat handshake
//   in_a, in_b, in_bv   operands; in_b counts as zero when in_bv=0
//   in_last             final beat of the job
//   out_valid/out_ready result handshake
//   out_sum, out_ovf    sum modulo 2^WIDTH, true sum >= 2^WIDTH
//   out_cycles          (CSA_ACCUM_CYCLE_CNT_EN only) busy cycles up to result
//
// Optional feature macro: CSA_ACCUM_CYCLE_CNT_EN
module csa_accum_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bv,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
`ifdef CSA_ACCUM_CYCLE_CNT_EN
 ,output logic [15:0]      out_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             oovf_q, oovf_d;

  // The 4:2 compressor row is built as two full-adder layers.
  // The first layer's carry (cout) depends only on S, C and in_a, so it feeds
  // bit i+1 of the second layer without forming a ripple chain.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] fa1_s;
  logic [WIDTH-1:0] row_cout;
  logic [WIDTH-1:0] row_cin;
  logic [WIDTH-1:0] row_o;
  logic [WIDTH-1:0] row_c1;
  logic [WIDTH-1:0] sc_and;

  always_comb begin
    b_eff    = in_b & {WIDTH{in_bv}};
    fa1_s    = s_q ^ c_q ^ in_a;
    row_cout = (s_q & c_q) | (s_q & in_a) | (c_q & in_a);
    row_cin  = {row_cout[WIDTH-2:0], 1'b0};
    row_o    = fa1_s ^ b_eff ^ row_cin;
    row_c1   = (fa1_s & b_eff) | (fa1_s & row_cin) | (b_eff & row_cin);
    sc_and   = s_q & c_q;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    oovf_d  = oovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = '0;
          c_d     = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          s_d   = row_o;
          c_d   = {row_c1[WIDTH-2:0], 1'b0};
          // Either carry leaving the top bit carries weight 2^WIDTH.
          ovf_d = ovf_q | row_c1[WIDTH-1] | row_cout[WIDTH-1];
          if (in_last) begin
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        // Each step adds at least one trailing zero to C, so the loop
        // ends after at most WIDTH iterations.
        if (c_q == '0) begin
          sum_d   = s_q;
          oovf_d  = ovf_q;
          state_d = DONE;
        end else begin
          s_d   = s_q ^ c_q;
          c_d   = {sc_and[WIDTH-2:0], 1'b0};
          ovf_d = ovf_q | sc_and[WIDTH-1];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      oovf_q  <= oovf_d;
    end
  end

  // The handshake flags are decoded from the registered state.
  // Because the state register resets asynchronously, these flags also
  // drop as soon as reset is asserted.
  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_ovf   = oovf_q;

`ifdef CSA_ACCUM_CYCLE_CNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic [15:0] cyc_q;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cnt_q <= '0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_inc;
      end
      // Capture the value the counter takes on the same edge that raises out_valid.
      if (state_q == RESOLVE && state_d == DONE) begin
        cyc_q <= cnt_inc;
      end
    end
  end

  assign out_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
module tb_csa_accum_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_bv = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         busy, in_ready, out_valid, out_ovf;
  logic [W-1:0] out_sum;
`ifdef CSA_ACCUM_CYCLE_CNT_EN
  logic [15:0]  out_cycles;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  bit           qbv[$];

  always #5 clk = ~clk;

  csa_accum_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bv     (in_bv),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
`ifdef CSA_ACCUM_CYCLE_CNT_EN
   ,.out_cycles(out_cycles)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit bv, input bit last, input string tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_bv    = bv;
    in_last  = last;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
  endtask

  // Reference: plain integer sum of all contributing operands.
  task automatic run_job(input string tag, input bit gaps, input bit hold);
    longint unsigned total;
    time             t0;
    int              n;
    logic [W-1:0]    esum;
    logic            eovf;
    total = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = $time;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < qa.size(); i++) begin
      total += longint'(qa[i]);
      if (qbv[i]) total += longint'(qb[i]);
      if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
      send_beat(qa[i], qb[i], qbv[i], (i == qa.size() - 1), tag);
    end
    esum = total[W-1:0];
    eovf = (total >> W) != 0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_latency_ok"}, {31'd0, (n >= 1 && n <= W + 1)}, 32'd1);
    chk({tag, "_sum"}, {16'd0, out_sum}, {16'd0, esum});
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eovf});
`ifdef CSA_ACCUM_CYCLE_CNT_EN
    chk({tag, "_cycles"}, {16'd0, out_cycles}, 32'(($time - t0) / 10));
`endif
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        start = (k == 2);
        step();
        start = 1'b0;
        chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_hold_sum"}, {16'd0, out_sum}, {16'd0, esum});
        chk({tag, "_hold_ovf"}, {31'd0, out_ovf}, {31'd0, eovf});
        chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      start = 1'b1;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid_end"}, {31'd0, out_valid}, 32'd0);
    if (hold) begin
      step();
      chk({tag, "_no_new_job"}, {31'd0, busy}, 32'd0);
    end
    qa.delete();
    qb.delete();
    qbv.delete();
  endtask

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input bit bv);
    qa.push_back(a);
    qb.push_back(b);
    qbv.push_back(bv);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return W'(16'hFFFF - W'($urandom_range(0, 3)));
      1:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (2) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    rst_n = 1'b1;
    step();

    add(16'd3, 16'd5, 1'b1);
    run_job("two_op", 1'b0, 1'b0);

    add(16'd1, 16'd2, 1'b1);
    add(16'd3, 16'd4, 1'b1);
    add(16'd5, 16'hFFFF, 1'b0);
    run_job("bv_zero", 1'b0, 1'b0);

    add(16'hFFFF, 16'h0001, 1'b1);
    run_job("wrap", 1'b0, 1'b0);

    add(16'h8000, 16'h8000, 1'b1);
    add(16'h0001, 16'h0000, 1'b1);
    run_job("drop_carry", 1'b0, 1'b0);

    add(16'h7FFF, 16'h0001, 1'b1);
    run_job("long_resolve", 1'b0, 1'b0);

    add(16'h1234, 16'h4321, 1'b1);
    add(16'hF000, 16'h0F00, 1'b1);
    run_job("hold", 1'b0, 1'b1);

    // Abort a job in flight with an asynchronous reset.
    start = 1'b1;
    step();
    start = 1'b0;
    send_beat(16'd100, 16'd200, 1'b1, 1'b0, "abort");
    send_beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "abort");
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_sum", {16'd0, out_sum}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    add(16'd10, 16'd20, 1'b1);
    run_job("after_abort", 1'b0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      int nb;
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) add(rnd_val(), rnd_val(), $urandom_range(0, 3) != 0);
      run_job($sformatf("rand%0d", j), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
